// File: rtl/psdifir_audio_pkg.sv
// Shared constants and small types for the PSD FIR audio output path.
// Sizes the I2S frame and names the two channel slots.
package psdifir_audio_pkg;

    localparam int AUDIO_W       = 18;
    localparam int BCLK_HALF_DEF = 16;
    localparam int SLOT_W_DEF    = 32;
    localparam int DATA_START    = 1;   // I2S: MSB one bclk after the word-select edge

    typedef enum logic {
        SLOT_LEFT  = 1'b0,
        SLOT_RIGHT = 1'b1
    } slot_e;

    function automatic int frame_bits(input int slot_w);
        return 2 * slot_w;
    endfunction

    localparam int FRAME_BITS_DEF = frame_bits(SLOT_W_DEF);

endpackage

// File: rtl/psdifir_i2s_tx_if.sv
// Sample-pair input and I2S/status outputs of the audio transmitter.
// The slave side is the transmitter; the master side feeds samples and watches the pins.
interface psdifir_i2s_tx_if
    import psdifir_audio_pkg::*;
#(
    parameter int DATA_W = AUDIO_W
) ();

    logic              datain_ready;
    logic [DATA_W-1:0] left_in;
    logic [DATA_W-1:0] right_in;
    logic              i2s_bclk;
    logic              i2s_lrclk;
    logic              i2s_sdata;
    logic              frame_start;
    logic              underrun;
    logic              overrun;

    modport master (
        output datain_ready, left_in, right_in,
        input  i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun, overrun
    );

    modport slave (
        input  datain_ready, left_in, right_in,
        output i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun, overrun
    );

endinterface

// File: rtl/psdifir_i2s_clkgen.sv
// Bit-clock divider and frame bit counter for the I2S transmitter.
// Strobes mark the falling bclk edge and the falling edge that starts a new frame.
module psdifir_i2s_clkgen
    import psdifir_audio_pkg::*;
#(
    parameter int BCLK_HALF = BCLK_HALF_DEF,
    parameter int SLOT_W    = SLOT_W_DEF
) (
    input  logic                              clk,
    input  logic                              rst_n,
    output logic                              i2s_bclk,
    output logic                              i2s_lrclk,
    output logic [$clog2(2*SLOT_W)-1:0]       bitcnt,
    output logic                              bclk_fall,
    output logic                              frame_tick
);

    localparam int FRAME_BITS = frame_bits(SLOT_W);
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam int DIV_W      = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_BITS - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             div_tc;
    logic [CNT_W-1:0] bitcnt_nxt;

    assign div_tc     = (div_cnt == DIV_LAST);
    assign bclk_fall  = div_tc & i2s_bclk;
    assign frame_tick = bclk_fall & (bitcnt == BIT_LAST);
    assign bitcnt_nxt = (bitcnt == BIT_LAST) ? '0 : bitcnt + 1'b1;

    // Word select is its own register so it reads 0 in reset while bitcnt sits at its last value.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            i2s_bclk  <= 1'b0;
            i2s_lrclk <= 1'b0;
            bitcnt    <= BIT_LAST;
        end else begin
            if (div_tc) begin
                div_cnt  <= '0;
                i2s_bclk <= ~i2s_bclk;
            end else begin
                div_cnt  <= div_cnt + 1'b1;
            end
            if (bclk_fall) begin
                bitcnt    <= bitcnt_nxt;
                i2s_lrclk <= bitcnt_nxt[CNT_W-1];
            end
        end
    end

endmodule

// File: rtl/psdifir_i2s_tx.sv
// I2S transmitter: one-deep holding buffer for the filtered stereo pair,
// frame-aligned capture into the transmit registers, and MSB-first serial data.
module psdifir_i2s_tx
    import psdifir_audio_pkg::*;
#(
    parameter int DATA_W    = AUDIO_W,
    parameter int BCLK_HALF = BCLK_HALF_DEF,
    parameter int SLOT_W    = SLOT_W_DEF
) (
    input  logic                  clockext100MHz,
    input  logic                  reset,
    psdifir_i2s_tx_if.slave       bus
);

    localparam int FRAME_BITS = frame_bits(SLOT_W);
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam int POS_W      = CNT_W - 1;
    localparam int IDX_W      = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(FRAME_BITS - 1);
    localparam logic [POS_W-1:0] POS_FIRST = POS_W'(DATA_START);
    localparam logic [POS_W-1:0] POS_LAST  = POS_W'(DATA_W);

    if (DATA_W >= SLOT_W) begin : g_width_check
        $error("psdifir_i2s_tx: DATA_W must be smaller than SLOT_W");
    end

    logic [CNT_W-1:0]  bitcnt;
    logic [CNT_W-1:0]  bitcnt_nxt;
    logic              bclk_fall;
    logic              frame_tick;

    logic [DATA_W-1:0] left_hold;
    logic [DATA_W-1:0] right_hold;
    logic              hold_valid;
    logic [DATA_W-1:0] left_sh;
    logic [DATA_W-1:0] right_sh;

    logic              sdata;
    logic              frame_start;
    logic              underrun;
    logic              overrun;

    slot_e             slot;
    logic [POS_W-1:0]  pos;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] sample;
    logic              sdata_nxt;

    psdifir_i2s_clkgen #(
        .BCLK_HALF (BCLK_HALF),
        .SLOT_W    (SLOT_W)
    ) u_clkgen (
        .clk        (clockext100MHz),
        .rst_n      (reset),
        .i2s_bclk   (bus.i2s_bclk),
        .i2s_lrclk  (bus.i2s_lrclk),
        .bitcnt     (bitcnt),
        .bclk_fall  (bclk_fall),
        .frame_tick (frame_tick)
    );

    // Data is chosen from the bit position the counter moves to on this falling edge.
    always_comb begin
        bitcnt_nxt = (bitcnt == BIT_LAST) ? '0 : bitcnt + 1'b1;
        slot       = slot_e'(bitcnt_nxt[CNT_W-1]);
        pos        = bitcnt_nxt[POS_W-1:0];
        sample     = (slot == SLOT_RIGHT) ? right_sh : left_sh;
        idx        = IDX_W'(POS_LAST - pos);
        sdata_nxt  = 1'b0;
        if (pos >= POS_FIRST && pos <= POS_LAST) begin
            sdata_nxt = sample[idx];
        end
    end

    // NOTE: the sample registers are ordinary flops, not a memory array, so they are reset like any other state.
    always_ff @(posedge clockext100MHz or negedge reset) begin
        if (!reset) begin
            left_hold   <= '0;
            right_hold  <= '0;
            hold_valid  <= 1'b0;
            left_sh     <= '0;
            right_sh    <= '0;
            sdata       <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_start <= frame_tick;
            underrun    <= frame_tick & ~hold_valid;
            overrun     <= bus.datain_ready & hold_valid & ~frame_tick;

            // An empty buffer at frame start leaves the transmit registers alone, resending the last pair.
            if (frame_tick && hold_valid) begin
                left_sh  <= left_hold;
                right_sh <= right_hold;
            end

            if (bus.datain_ready) begin
                left_hold  <= bus.left_in;
                right_hold <= bus.right_in;
                hold_valid <= 1'b1;
            end else if (frame_tick) begin
                hold_valid <= 1'b0;
            end

            if (bclk_fall) begin
                sdata <= sdata_nxt;
            end
        end
    end

    assign bus.i2s_sdata   = sdata;
    assign bus.frame_start = frame_start;
    assign bus.underrun    = underrun;
    assign bus.overrun     = overrun;

endmodule

// File: tb/tb_psdifir_i2s_tx.sv
// Directed bench for psdifir_i2s_tx: a queue holds the pair expected in the next
// frame; each frame start pops it and the captured serial frame is compared bit for bit.
module tb_psdifir_i2s_tx;

    typedef struct packed {
        logic [17:0] l;
        logic [17:0] r;
    } pair_t;

    logic clk;
    logic reset;
    int   cyc;
    int   vectors;
    int   miscompares;
    int   fs_cyc;

    pair_t sb[$];
    pair_t last_sent;
    pair_t cur;

    psdifir_i2s_tx_if #(.DATA_W(18)) bus ();

    psdifir_i2s_tx dut (
        .clockext100MHz (clk),
        .reset          (reset),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_frame(input pair_t p);
        logic [63:0] f;
        f = '0;
        for (int k = 1; k <= 18; k++) begin
            f[k]      = p.l[18-k];
            f[32 + k] = p.r[18-k];
        end
        return f;
    endfunction

    function automatic logic [63:0] pins();
        return 64'({bus.i2s_bclk, bus.i2s_lrclk, bus.i2s_sdata,
                    bus.frame_start, bus.underrun, bus.overrun});
    endfunction

    // Strobe one pair; hold is full (overrun expected) whenever the queue already has an entry.
    task automatic strobe(input string tag, input logic [17:0] l, input logic [17:0] r);
        logic exp_ov;
        pair_t p;
        p.l = l;
        p.r = r;
        exp_ov = (sb.size() > 0);
        if (exp_ov) void'(sb.pop_back());
        sb.push_back(p);
        bus.left_in      = l;
        bus.right_in     = r;
        bus.datain_ready = 1'b1;
        @(negedge clk);
        bus.datain_ready = 1'b0;
        check({tag, "_overrun"}, 64'(bus.overrun), 64'(exp_ov));
    endtask

    task automatic frame_event(input string tag, input int exp_cyc, input bit chk_lr);
        bit   found;
        logic prev_lr;
        logic exp_ur;
        found   = 1'b0;
        prev_lr = bus.i2s_lrclk;
        for (int k = 0; k < 2200 && !found; k++) begin
            prev_lr = bus.i2s_lrclk;
            @(negedge clk);
            found = bus.frame_start;
        end
        check({tag, "_seen"}, 64'(found), 64'd1);
        if (sb.size() > 0) begin
            cur    = sb.pop_front();
            exp_ur = 1'b0;
        end else begin
            cur    = last_sent;
            exp_ur = 1'b1;
        end
        last_sent = cur;
        fs_cyc    = cyc;
        check({tag, "_cycle"},    64'(cyc),          64'(exp_cyc));
        check({tag, "_underrun"}, 64'(bus.underrun), 64'(exp_ur));
        check({tag, "_overrun"},  64'(bus.overrun),  64'd0);
        if (chk_lr) begin
            check({tag, "_lr_edge"}, 64'({prev_lr, bus.i2s_lrclk}), 64'b10);
        end
    endtask

    // Sample sdata and lrclk on each rising bclk, as the DAC does.
    task automatic capture(input string tag);
        logic [63:0] sd;
        logic [63:0] lr;
        logic [63:0] lr_exp;
        logic        pb;
        logic        rise;
        bit          ok;
        int          guard;
        sd     = '0;
        lr     = '0;
        lr_exp = {32'hFFFF_FFFF, 32'h0000_0000};
        ok     = 1'b1;
        pb     = bus.i2s_bclk;
        for (int i = 0; i < 64; i++) begin
            guard = 0;
            rise  = 1'b0;
            while (!rise && guard < 64) begin
                @(negedge clk);
                guard++;
                rise = bus.i2s_bclk & ~pb;
                pb   = bus.i2s_bclk;
            end
            if (!rise) ok = 1'b0;
            sd[i] = bus.i2s_sdata;
            lr[i] = bus.i2s_lrclk;
        end
        check({tag, "_bclk_alive"}, 64'(ok), 64'd1);
        check({tag, "_sdata"},      sd,      exp_frame(cur));
        check({tag, "_lrclk"},      lr,      lr_exp);
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        last_sent        = '0;
        cur              = '0;
        fs_cyc           = 0;
        bus.datain_ready = 1'b0;
        bus.left_in      = '0;
        bus.right_in     = '0;
        reset            = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_pins", pins(), 64'd0);
        reset = 1'b1;

        // Idle start-up: underruns with an all-zero frame.
        frame_event("f1", 32, 1'b0);
        capture("f1");
        frame_event("f2", fs_cyc + 2048, 1'b1);

        strobe("s_2a5f3", 18'h2A5F3, 18'h1FFFF);
        frame_event("f3", fs_cyc + 2048, 1'b1);
        capture("f3");

        strobe("s_neg", 18'h20000, 18'h00001);
        frame_event("f4", fs_cyc + 2048, 1'b1);
        capture("f4");

        // Nothing loaded: previous pair is resent.
        frame_event("f5", fs_cyc + 2048, 1'b1);
        capture("f5");

        strobe("s_a", 18'h12345, 18'h0ABCD);
        strobe("s_b", 18'h3C3C3, 18'h05A5A);
        frame_event("f6", fs_cyc + 2048, 1'b1);
        capture("f6");

        // Strobe lands on the frame-start edge while hold already has X.
        strobe("s_x", 18'h15555, 18'h2AAAA);
        for (int k = 0; k < 40 && cyc != fs_cyc + 2047; k++) @(negedge clk);
        bus.left_in      = 18'h0F0F0;
        bus.right_in     = 18'h30303;
        bus.datain_ready = 1'b1;
        @(negedge clk);
        bus.datain_ready = 1'b0;
        check("f7_seen",     64'(bus.frame_start), 64'd1);
        check("f7_cycle",    64'(cyc),             64'(fs_cyc + 2048));
        check("f7_underrun", 64'(bus.underrun),    64'd0);
        check("f7_overrun",  64'(bus.overrun),     64'd0);
        cur       = sb.pop_front();
        last_sent = cur;
        fs_cyc    = cyc;
        sb.push_back({18'h0F0F0, 18'h30303});
        capture("f7");
        frame_event("f8", fs_cyc + 2048, 1'b1);
        capture("f8");

        // Reset in the right slot of a frame with a fresh pair waiting in hold.
        frame_event("f9", fs_cyc + 2048, 1'b1);
        repeat (1400) @(negedge clk);
        strobe("s_z", 18'h2FFFF, 18'h10001);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1 check("midreset_pins_now", pins(), 64'd0);
        sb.delete();
        last_sent = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("midreset_pins_%0d", k), pins(), 64'd0);
        end
        reset = 1'b1;
        frame_event("r1", 32, 1'b0);
        capture("r1");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
